seq1101_framer: RTL and testbench

Serial frame transmitter: the transmit end of the 1101 sync-word link. It accepts a DATA_W-bit word over a valid/ready handshake and serialises it MSB first behind the 4-bit sync preamble 1101. With stuffing compiled in, an overlapping 1101 Mealy detector at the far end matches exactly once per frame, on the last preamble bit. It sits between the word-level producer and the serial line that feeds the 1101 sequence detector.

---
 rtl/seq1101_framer.sv | 95 +++++++++
 tb/tb_seq1101_framer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seq1101_framer.sv
// seq1101_framer: serialises a DATA_W-bit word MSB first behind a 1101 preamble; SEQ1101_STUFF_EN enables zero stuffing.
module seq1101_framer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              bit_valid,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, PRE, PAY, STF} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [1:0]        pre_cnt, pre_cnt_n;
  logic              out_n, bit_valid_n, done_n;
  logic              stuff, tail;
  assign in_ready = (state == IDLE) && !rst;
`ifdef SEQ1101_STUFF_EN
  logic [2:0] hist, hist_n;
  assign stuff  = hist == 3'b110;
  assign tail   = {hist[1:0], sr[DATA_W-1]} == 3'b110;
  assign hist_n = (state == IDLE && in_valid) ? 3'b001 :
                  bit_valid_n ? {hist[1:0], out_n} : hist;
  always_ff @(posedge clk)
    hist <= rst ? 3'b000 : hist_n;
`else
  assign stuff = 1'b0;
  assign tail  = 1'b0;
`endif
  // state names what is on the line now; each edge picks the next bit
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bit_cnt_n   = bit_cnt;
    pre_cnt_n   = pre_cnt;
    out_n       = 1'b0;
    bit_valid_n = 1'b0;
    done_n      = 1'b0;
    if (state == IDLE) begin
      if (in_valid) begin
        state_n     = PRE;
        sr_n        = in_data;
        bit_cnt_n   = CW'(DATA_W);
        pre_cnt_n   = 2'd1;
        out_n       = 1'b1;
        bit_valid_n = 1'b1;
      end
    end else if (state == PRE) begin
      out_n       = pre_cnt != 2'd2;
      bit_valid_n = 1'b1;
      pre_cnt_n   = pre_cnt + 2'd1;
      state_n     = pre_cnt == 2'd3 ? PAY : PRE;
    end else if (bit_cnt != '0) begin
      bit_valid_n = 1'b1;
      if (stuff) begin
        state_n = STF;
      end else begin
        out_n     = sr[DATA_W-1];
        sr_n      = sr << 1;
        bit_cnt_n = bit_cnt - CW'(1);
        state_n   = PAY;
        done_n    = bit_cnt == CW'(1) && !tail;
      end
    end else if (state == PAY && stuff) begin
      state_n     = STF;
      bit_valid_n = 1'b1;
      done_n      = 1'b1;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
      out       <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bit_cnt   <= bit_cnt_n;
      pre_cnt   <= pre_cnt_n;
      out       <= out_n;
      bit_valid <= bit_valid_n;
      done      <= done_n;
    end
endmodule

// File: tb/tb_seq1101_framer.sv
// tb_seq1101_framer: directed frames with hand-computed bit patterns; expectations follow SEQ1101_STUFF_EN.
module tb_seq1101_framer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out, bit_valid, done;
  int         total = 0;
  int         bad = 0;
  logic [3:0] dh;
  int         fires;
`ifdef SEQ1101_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  seq1101_framer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .bit_valid(bit_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // gathers bits while bit_valid is high, feeding a far-end 1101 detector
  task automatic collect(output logic [15:0] bits, output int len, output int dpos, output int dcnt);
    bits = '0;
    len  = 0;
    dpos = 0;
    dcnt = 0;
    for (int i = 0; i < 20 && bit_valid; i++) begin
      bits = {bits[14:0], out};
      len++;
      dh = {dh[2:0], out};
      if (dh == 4'b1101) fires++;
      if (done) begin
        dpos = len;
        dcnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] w, input logic [15:0] eb, input int el, input int ef);
    logic [15:0] b;
    int l, dp, dc;
    dh    = 4'b0000;
    fires = 0;
    send(w);
    collect(b, l, dp, dc);
    check({tag, "_bits"}, 32'(b), 32'(eb));
    check({tag, "_len"}, 32'(l), 32'(el));
    check({tag, "_donepos"}, 32'(dp), 32'(el));
    check({tag, "_donecnt"}, 32'(dc), 32'd1);
    check({tag, "_det"}, 32'(fires), 32'(ef));
    check({tag, "_idle"}, {29'd0, in_ready, bit_valid, out}, 32'b100);
  endtask

  initial begin
    logic [15:0] b1, b2;
    int l1, l2, dp1, dp2, dc1, dc2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_bv", 32'(bit_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    frame("ff", 8'hFF, 16'h0DFF, 12, 1);
    frame("d0", 8'hD0, STUFF ? 16'h1B90 : 16'h0DD0, STUFF ? 13 : 12, STUFF ? 1 : 2);
    frame("06", 8'h06, STUFF ? 16'h1A0C : 16'h0D06, STUFF ? 13 : 12, 1);

    dh    = 4'b0000;
    fires = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h06;
    @(negedge clk);
    in_data = 8'hFF;
    collect(b1, l1, dp1, dc1);
    check("b2b_gap_bv", 32'(bit_valid), 32'd0);
    check("b2b_gap_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    collect(b2, l2, dp2, dc2);
    check("b2b_bits1", 32'(b1), STUFF ? 32'h1A0C : 32'h0D06);
    check("b2b_len1", 32'(l1), STUFF ? 32'd13 : 32'd12);
    check("b2b_bits2", 32'(b2), 32'h0DFF);
    check("b2b_len2", 32'(l2), 32'd12);
    check("b2b_done", 32'(dc1 + dc2), 32'd2);
    check("b2b_det", 32'(fires), STUFF ? 32'd2 : 32'd3);

    send(8'hA5);
    repeat (6) @(negedge clk);
    check("abort_bv_before", 32'(bit_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out", 32'(out), 32'd0);
    check("abort_bv", 32'(bit_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_idle_bv", 32'(bit_valid), 32'd0);
    frame("post", 8'hFF, 16'h0DFF, 12, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
